// File: rtl/sign_restore.sv
// sign_restore: re-applies operand signs to the unsigned result of a mul/div
// core. A small tag FIFO remembers {op, Sign1, Sign2} for each issued op and
// pairs it in order with the next unsigned core result; the signed result is
// held in a one-entry output register with valid/ready handshaking.
module sign_restore #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tag_valid,
    output logic                   tag_ready,
    input  logic                   Sign1,
    input  logic                   Sign2,
    input  logic                   op,
    output logic [$clog2(DEPTH):0] tag_count,
    input  logic                   core_valid,
    output logic                   core_ready,
    input  logic [WIDTH-1:0]       Uns1,
    input  logic [WIDTH-1:0]       Uns2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       res1,
    output logic [WIDTH-1:0]       res2
);

    // Pointer width is kept at least one bit so DEPTH=1 still elaborates.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic op;   // 0 = multiply, 1 = divide
        logic s1;   // sign of operand 1 (dividend for divide)
        logic s2;   // sign of operand 2
    } tag_t;

    // Tag storage and bookkeeping
    tag_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Output register
    logic             r_out_valid;
    logic [WIDTH-1:0] r_res1;
    logic [WIDTH-1:0] r_res2;

    // Handshake and datapath wires
    logic             w_push;
    logic             w_pop;
    tag_t             w_head;
    logic             w_neg_q;
    logic             w_neg_r;
    logic             w_neg_m;
    logic [WIDTH-1:0] w_lo_inv;
    logic [WIDTH-1:0] w_lo_neg;
    logic             w_lo_carry;
    logic [WIDTH-1:0] w_hi_neg;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_div_r;
    logic [WIDTH-1:0] w_nxt1;
    logic [WIDTH-1:0] w_nxt2;

    // Advance a FIFO pointer, wrapping at DEPTH.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) return '0;
        return p + AW'(1);
    endfunction

    // Two's-complement negate when en is set; -0 = 0 and the most negative
    // value maps to itself, both falling out of plain modular arithmetic.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic en);
        if (en) return ~x + WIDTH'(1);
        return x;
    endfunction

    // Ready signals are purely combinational; a pop in the same cycle does
    // not free space for a push, which keeps the FIFO full check trivial.
    assign tag_ready  = !rst && (r_count < CW'(DEPTH));
    assign core_ready = !rst && (r_count != '0) && (!r_out_valid || out_ready);

    assign w_push = tag_valid && tag_ready;
    assign w_pop  = core_valid && core_ready;
    assign w_head = r_mem[r_rptr];

    assign tag_count = r_count;
    assign out_valid = r_out_valid;
    assign res1      = r_res1;
    assign res2      = r_res2;

    // Sign selection for the head tag: product sign for multiply and
    // quotient, dividend sign for the remainder.
    assign w_neg_m = w_head.s1 ^ w_head.s2;
    assign w_neg_q = w_head.s1 ^ w_head.s2;
    assign w_neg_r = w_head.s1;

    // Double-width negate split into halves: the low word's +1 carries into
    // the high word only when the low word is zero (the borrow chain).
    assign w_lo_inv               = ~Uns2;
    assign {w_lo_carry, w_lo_neg} = {1'b0, w_lo_inv} + {{WIDTH{1'b0}}, 1'b1};
    assign w_hi_neg               = ~Uns1 + {{(WIDTH-1){1'b0}}, w_lo_carry};

    assign w_div_q = cond_neg(Uns1, w_neg_q);
    assign w_div_r = cond_neg(Uns2, w_neg_r);

    // Pick the signed result for whichever operation the head tag describes.
    always_comb begin
        w_nxt1 = Uns1;
        w_nxt2 = Uns2;
        if (w_head.op) begin
            w_nxt1 = w_div_q;
            w_nxt2 = w_div_r;
        end else if (w_neg_m) begin
            w_nxt1 = w_hi_neg;
            w_nxt2 = w_lo_neg;
        end
    end

    // Tag payload write; storage needs no reset since only counted entries are read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= tag_t'({op, Sign1, Sign2});
    end

    // Pointer and occupancy tracking for the tag FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: load on core handshake, drop valid when consumed,
    // otherwise hold so the consumer sees a stable result under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res1      <= '0;
            r_res2      <= '0;
        end else if (w_pop) begin
            r_out_valid <= 1'b1;
            r_res1      <= w_nxt1;
            r_res2      <= w_nxt2;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sign_restore.sv
// Testbench for sign_restore: a queue-based model of the tag FIFO and the
// signed result is checked against the DUT every cycle, and directed vectors
// carry hand-computed literal expectations.
module tb_sign_restore;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              tag_valid;
    logic              tag_ready;
    logic              Sign1;
    logic              Sign2;
    logic              op;
    logic [2:0]        tag_count;
    logic              core_valid;
    logic              core_ready;
    logic [WIDTH-1:0]  Uns1;
    logic [WIDTH-1:0]  Uns2;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  res1;
    logic [WIDTH-1:0]  res2;

    int n_vec  = 0;
    int n_miss = 0;

    sign_restore #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tag_valid(tag_valid), .tag_ready(tag_ready),
        .Sign1(Sign1), .Sign2(Sign2), .op(op),
        .tag_count(tag_count),
        .core_valid(core_valid), .core_ready(core_ready),
        .Uns1(Uns1), .Uns2(Uns2),
        .out_valid(out_valid), .out_ready(out_ready),
        .res1(res1), .res2(res2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [2:0]  mq[$];
    logic        m_ov = 1'b0;
    logic [31:0] m_r1 = '0;
    logic [31:0] m_r2 = '0;
    bit          m_started = 1'b0;

    // Signed result from sign rules using plain modular arithmetic.
    function automatic logic [63:0] exp_res(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        logic neg;
        neg = t[1] ^ t[0];
        if (!t[2]) return neg ? (64'd0 - {a, b}) : {a, b};
        return {(neg ? 32'd0 - a : a), (t[1] ? 32'd0 - b : b)};
    endfunction

    function automatic bit m_pop_ok();
        return core_valid && (mq.size() != 0) && (!m_ov || out_ready);
    endfunction

    task automatic model_pop();
        {m_r1, m_r2} <= exp_res(mq[0], Uns1, Uns2);
        m_ov <= 1'b1;
        void'(mq.pop_front());
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ov      <= 1'b0;
            m_r1      <= '0;
            m_r2      <= '0;
            m_started <= 1'b1;
        end else if (tag_valid && mq.size() < DEPTH) begin
            if (m_pop_ok()) model_pop();
            else if (out_ready) m_ov <= 1'b0;
            mq.push_back({op, Sign1, Sign2});
        end else begin
            if (m_pop_ok()) model_pop();
            else if (out_ready) m_ov <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("tag_ready",  64'(tag_ready),  64'(!rst && mq.size() < DEPTH));
            chk("core_ready", 64'(core_ready), 64'(!rst && mq.size() != 0 && (!m_ov || out_ready)));
            chk("tag_count",  64'(tag_count),  64'(mq.size()));
            chk("out_valid",  64'(out_valid),  64'(m_ov));
            chk("res1",       64'(res1),       64'(m_r1));
            chk("res2",       64'(res2),       64'(m_r2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tag(input logic o, input logic s1, input logic s2);
        op = o; Sign1 = s1; Sign2 = s2;
    endtask

    // One op end to end with a literal expectation on the signed result.
    task automatic txn(input string nm, input logic o, input logic s1, input logic s2,
                       input logic [31:0] u1, input logic [31:0] u2,
                       input logic [31:0] e1, input logic [31:0] e2);
        cyc();
        tag_valid = 1'b1; set_tag(o, s1, s2);
        cyc();
        tag_valid = 1'b0; core_valid = 1'b1; Uns1 = u1; Uns2 = u2; out_ready = 1'b1;
        cyc();
        core_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_res1"},  64'(res1), 64'(e1));
        chk({nm, "_res2"},  64'(res2), 64'(e2));
        chk({nm, "_model"}, {m_r1, m_r2}, {e1, e2});
    endtask

    initial begin
        rst = 1'b1; tag_valid = 1'b0; core_valid = 1'b0; out_ready = 1'b1;
        set_tag(1'b0, 1'b0, 1'b0); Uns1 = '0; Uns2 = '0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_tag_ready",  64'(tag_ready),  64'd0);
        chk("rst_core_ready", 64'(core_ready), 64'd0);
        chk("rst_count",      64'(tag_count),  64'd0);
        chk("rst_res",        {res1, res2},    64'd0);
        cyc();
        rst = 1'b0;

        // Sign restoration vectors
        txn("mul_neg6",  1'b0, 1'b1, 1'b0, 32'h0, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFA);
        txn("div_m7_2",  1'b1, 1'b1, 1'b0, 32'd3, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF);
        txn("div_7_m2",  1'b1, 1'b0, 1'b1, 32'd3, 32'd1, 32'hFFFFFFFD, 32'h00000001);
        txn("mul_borrow",1'b0, 1'b0, 1'b1, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h00000000);
        txn("div_minint",1'b1, 1'b1, 1'b1, 32'h80000000, 32'h5, 32'h80000000, 32'hFFFFFFFB);
        txn("div_negmin",1'b1, 1'b1, 1'b0, 32'h80000000, 32'h0, 32'h80000000, 32'h00000000);
        txn("mul_zero",  1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h00000000, 32'h00000000);
        txn("mul_pos",   1'b0, 1'b1, 1'b1, 32'h12, 32'h34, 32'h00000012, 32'h00000034);

        // Full FIFO: the fifth push must be dropped
        cyc();
        tag_valid = 1'b1; set_tag(1'b0, 1'b1, 1'b0);
        cyc(); set_tag(1'b1, 1'b1, 1'b1);
        cyc(); set_tag(1'b0, 1'b0, 1'b1);
        cyc(); set_tag(1'b1, 1'b0, 1'b0);
        cyc(); set_tag(1'b0, 1'b1, 1'b1);
        cyc(); tag_valid = 1'b0;
        @(negedge clk);
        chk("full_count", 64'(tag_count), 64'd4);
        chk("full_ready", 64'(tag_ready), 64'd0);
        cyc();
        core_valid = 1'b1; Uns1 = 32'h0; Uns2 = 32'h1;
        cyc();
        core_valid = 1'b0;
        @(negedge clk);
        chk("pop1_count", 64'(tag_count), 64'd3);
        chk("pop1_ready", 64'(tag_ready), 64'd1);
        chk("pop1_res",   {res1, res2}, 64'hFFFFFFFF_FFFFFFFF);
        cyc();
        core_valid = 1'b1; Uns1 = 32'd7; Uns2 = 32'd3;
        cyc();
        Uns1 = 32'h10; Uns2 = 32'h20;
        @(negedge clk);
        chk("pop2_res", {res1, res2}, 64'h00000007_FFFFFFFD);
        cyc();
        Uns1 = 32'd5; Uns2 = 32'd5;
        @(negedge clk);
        chk("pop3_res", {res1, res2}, 64'hFFFFFFEF_FFFFFFE0);
        cyc();
        core_valid = 1'b0;
        @(negedge clk);
        chk("pop4_res",   {res1, res2}, 64'h00000005_00000005);
        chk("drain_count", 64'(tag_count), 64'd0);

        // Backpressure: result held, then replaced with no bubble
        cyc();
        out_ready = 1'b0; tag_valid = 1'b1; set_tag(1'b0, 1'b0, 1'b1);
        cyc(); set_tag(1'b1, 1'b0, 1'b0);
        cyc();
        tag_valid = 1'b0; core_valid = 1'b1; Uns1 = 32'h0; Uns2 = 32'h2;
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_res",   {res1, res2}, 64'hFFFFFFFF_FFFFFFFE);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_core_ready", 64'(core_ready), 64'd0);
        end
        cyc();
        out_ready = 1'b1;
        cyc();
        core_valid = 1'b0;
        @(negedge clk);
        chk("bp_swap_valid", 64'(out_valid), 64'd1);
        chk("bp_swap_res",   {res1, res2}, 64'h00000000_00000002);

        // Reset in the middle of operation
        cyc();
        out_ready = 1'b0; tag_valid = 1'b1; set_tag(1'b0, 1'b1, 1'b1);
        cyc(); set_tag(1'b1, 1'b1, 1'b0);
        cyc(); set_tag(1'b0, 1'b1, 1'b0);
        cyc();
        tag_valid = 1'b0; core_valid = 1'b1; Uns1 = 32'h1; Uns2 = 32'h1;
        cyc();
        core_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_count", 64'(tag_count), 64'd2);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; core_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", 64'(tag_count), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_res",   {res1, res2}, 64'd0);
        repeat (3) cyc();
        @(negedge clk);
        chk("post_rst_ignored", 64'(out_valid), 64'd0);
        cyc();
        tag_valid = 1'b1; set_tag(1'b1, 1'b0, 1'b1);
        cyc();
        tag_valid = 1'b0; out_ready = 1'b1;
        cyc();
        core_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_res",   {res1, res2}, 64'hFFFFFFFF_00000001);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
